// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: interval counter with prescaler, pause/hold,
// one-shot or auto-reload periodic operation and start rejection.
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic active;
  logic tick;
  logic do_stop, do_load, do_rej;
  logic do_hold, do_cnt;

  assign active = (state_q == RUN) || (state_q == HOLD);
  assign tick   = (presc_q == PMAX);

  // one-hot command decode: stop > start > pause
  assign do_stop = stop;
  assign do_load = !stop && start && (period != '0);
  assign do_rej  = !stop && start && (period == '0);
  assign do_hold = !stop && !start && pause && active;
  assign do_cnt  = !stop && !start && !pause && active;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
    period_d = period_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (1'b1)
      do_stop: begin
        state_d = IDLE;
        count_d = '0;
        presc_d = '0;
      end
      do_load: begin
        state_d  = RUN;
        period_d = period;
        count_d  = '0;
        presc_d  = '0;
      end
      do_rej: begin
        err_d = 1'b1;
      end
      do_hold: begin
        state_d = HOLD;
      end
      // leaving HOLD counts on the same edge so no clock is lost
      do_cnt: begin
        state_d = RUN;
        if (tick) begin
          presc_d = '0;
          if (count_q == period_q) begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d  = '0;
              period_d = period;
            end else begin
              state_d = DONE;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign busy  = active;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, setting the count and period width in bits.
REQ-002 The module SHALL have parameter DIV, default 1, setting clocks per count tick; legal range is 1 or more.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: level-sampled request to begin or restart an interval.
REQ-006 The module SHALL have port stop, input, 1 bit: abort the interval and return to idle.
REQ-007 The module SHALL have port pause, input, 1 bit: freeze counting while high.
REQ-008 The module SHALL have port auto_reload, input, 1 bit: 1 selects periodic mode, 0 selects one-shot mode; sampled at the terminal tick.
REQ-009 The module SHALL have port period, input, WIDTH bits: terminal count value; latched on start accept and on each auto-reload.
REQ-010 The module SHALL have port count, output, WIDTH bits: the current count value.
REQ-011 The module SHALL have port busy, output, 1 bit: high in RUN or HOLD.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse at interval completion.
REQ-013 The module SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-014 The module SHALL implement the states IDLE, RUN, HOLD and DONE.
REQ-015 Command priority SHALL be stop, then start, then pause, in every state.
REQ-016 When stop=1 in any state, the next state SHALL be IDLE with count=0 and prescaler=0; no done pulse is generated.
REQ-017 Start accept (in IDLE, RUN, HOLD or DONE, with period!=0) SHALL latch period into period_q, clear count and the prescaler, and enter RUN on the next edge.
REQ-018 A start with period==0 SHALL be rejected: err=1 for one cycle and the state is unchanged.
REQ-019 In RUN, a prescaler SHALL count 0..DIV-1, and a tick SHALL occur on the edge where prescaler==DIV-1, after which the prescaler wraps to 0.
REQ-020 On a tick with count!=period_q, count SHALL increment by 1.
REQ-021 On a tick with count==period_q and auto_reload=1, count SHALL become 0, period SHALL be relatched, done=1 next cycle, and the state SHALL remain RUN.
REQ-022 On a tick with count==period_q and auto_reload=0, the state SHALL become DONE, count SHALL hold period_q, and done=1 next cycle.
REQ-023 The interval length SHALL be (period_q+1)*DIV clocks from start accept to the done pulse.
REQ-024 In RUN with pause=1 and no stop or start, the state SHALL go to HOLD; count and prescaler SHALL be frozen.
REQ-025 In HOLD, pause=0 SHALL return to RUN and resume from the frozen prescaler value; no tick is lost or added.
REQ-026 DONE SHALL hold count until a start (restart) or a stop (IDLE, count=0).
REQ-027 In IDLE and DONE, pause SHALL have no effect.
REQ-028 done and err SHALL be registered outputs, each high for exactly one cycle per event.
REQ-029 Count arithmetic SHALL be WIDTH bits and never exceed period_q; period=2^WIDTH-1 SHALL be legal.

Reset
REQ-030 When rst_n=0, the block SHALL immediately enter IDLE with count=0, prescaler=0, period_q=0, busy=0, done=0 and err=0, regardless of clk.
REQ-031 Reset asserted mid-interval SHALL discard the interval with no done pulse; after release, the block SHALL remain in IDLE until the next start.

Verification (WIDTH=8, DIV=1 unless stated)
REQ-032 The bench SHALL cover one-shot: period=5, auto_reload=0, start pulsed at edge E0 -> count 0,1..5 at E0..E5; at E6 state=DONE, done=1 for one cycle, count holds 5, busy=0.
REQ-033 The bench SHALL cover periodic: period=3, auto_reload=1 -> count sequence 0,1,2,3,0,1,..; done pulses every 4 cycles; busy stays 1.
REQ-034 The bench SHALL cover pause: DIV=4, period=2, pause high for 10 cycles mid-interval -> count and prescaler frozen; done arrives 12+10 clocks after start.
REQ-035 The bench SHALL cover priority: stop=1 and start=1 together in RUN -> IDLE, count=0, no done; later start with period=0 -> err=1 for one cycle, state stays IDLE.
REQ-036 The bench SHALL cover async reset: rst_n low between clock edges while count=4 -> count=0 and busy=0 before the next edge; no done after release.
REQ-037 The bench SHALL cover restart: start while count=3 of period=7 -> count=0 on the next edge, and done occurs 8 cycles after the restart.
